// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the SRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Port indices: instruction fetch and data-cache miss/write path
    localparam int PORT_IF  = 0;
    localparam int PORT_MEM = 1;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Two-way winner selection. A lone requester always wins; on
//               contention either the port not granted last (RR=1) or the
//               fixed-priority port 1 (RR=0) wins. One-hot output.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_win
);

    // Contention resolution; uncontended requests pass straight through
    always_comb begin
        o_win = i_req;
        if (i_req == 2'b11) begin
            if (RR) begin
                o_win = i_last ? 2'b01 : 2'b10;
            end else begin
                o_win = 2'b10;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Shares one SramController between the instruction-fetch port
//               (0) and the data-cache port (1). Registers the winning request
//               onto the controller, holds it until completion, and steers
//               completion and read data back to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import arb_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_r_en,
    input  logic        req0_w_en,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic [63:0] req0_rdata,
    output logic        req0_ready,
    input  logic        req1_r_en,
    input  logic        req1_w_en,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic [63:0] req1_rdata,
    output logic        req1_ready,
    output logic        sram_r_en,
    output logic        sram_w_en,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready,
    output logic [1:0]  grant,
    output logic        busy
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        w_load;
    logic [1:0]  w_req;
    logic [1:0]  w_win;
    logic        w_sel;
    logic        w_win_r;
    logic        w_win_w;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_wdata;
    logic        w_done;
    logic        r_first;
    logic        r_last;
    logic [1:0]  r_grant;
    logic [63:0] r_rdata0;
    logic [63:0] r_rdata1;

    assign w_req[PORT_IF]  = req0_r_en | req0_w_en;
    assign w_req[PORT_MEM] = req1_r_en | req1_w_en;

    rr_pick2 #(
        .RR (RR)
    ) u_pick (
        .i_req  (w_req),
        .i_last (r_last),
        .o_win  (w_win)
    );

    // Steer the winner's request fields toward the controller registers
    assign w_sel       = w_win[PORT_MEM];
    assign w_win_r     = w_sel ? req1_r_en  : req0_r_en;
    assign w_win_w     = w_sel ? req1_w_en  : req0_w_en;
    assign w_win_addr  = w_sel ? req1_addr  : req0_addr;
    assign w_win_wdata = w_sel ? req1_wdata : req0_wdata;

    // The first BUSY cycle still sees the controller's idle-ready level
    assign w_done = (r_state == BUSY) && !r_first && sram_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and request-load strobe
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = BUSY;
                    w_load      = 1'b1;
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Controller-side registers, ownership tracking and read-data capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            sram_r_en  <= 1'b0;
            sram_w_en  <= 1'b0;
            sram_addr  <= 32'h0;
            sram_wdata <= 32'h0;
            r_grant    <= 2'b00;
            r_first    <= 1'b0;
            r_last     <= 1'b1;
            r_rdata0   <= 64'h0;
            r_rdata1   <= 64'h0;
        end else if (w_load) begin
            // A combined read+write request is performed as a write
            sram_r_en  <= w_win_r & ~w_win_w;
            sram_w_en  <= w_win_w;
            sram_addr  <= w_win_addr;
            sram_wdata <= w_win_wdata;
            r_grant    <= w_win;
            r_first    <= 1'b1;
        end else if (r_state == BUSY) begin
            r_first <= 1'b0;
            if (w_done) begin
                sram_r_en <= 1'b0;
                sram_w_en <= 1'b0;
                r_grant   <= 2'b00;
                r_last    <= r_grant[PORT_MEM];
                if (r_grant[PORT_IF]) begin
                    r_rdata0 <= sram_rdata;
                end
                if (r_grant[PORT_MEM]) begin
                    r_rdata1 <= sram_rdata;
                end
            end
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == BUSY);

    // Ready is high for idle ports and for the owner's completion cycle
    assign req0_ready = rst & (~w_req[PORT_IF]  | (w_done & r_grant[PORT_IF]));
    assign req1_ready = rst & (~w_req[PORT_MEM] | (w_done & r_grant[PORT_MEM]));

    // Completion data bypasses the capture register for zero-latency return
    assign req0_rdata = (w_done & r_grant[PORT_IF])  ? sram_rdata : r_rdata0;
    assign req1_rdata = (w_done & r_grant[PORT_MEM]) ? sram_rdata : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Scoreboard bench for sram_arbiter. Two instances: index 0 is
//               round-robin, index 1 is fixed priority. Each has its own
//               controller model and transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_en  [2][2];
    logic        w_en  [2][2];
    logic [31:0] addr  [2][2];
    logic [31:0] wdata [2][2];
    logic [63:0] rdata [2][2];
    logic        rdy   [2][2];
    logic        s_r [2];
    logic        s_w [2];
    logic [31:0] s_addr  [2];
    logic [31:0] s_wdata [2];
    logic [63:0] s_rdata [2];
    logic        s_rdy [2];
    logic [1:0]  grant [2];
    logic        busy  [2];

    int          lat   [2];
    int          c_cnt [2];
    int          n_checks = 0;
    int          n_err    = 0;

    // Expected transactions per (instance, port), pushed at issue time
    txn_t        exp_q [4][$];

    // Reference-model state per instance
    logic        e_valid = 1'b0;
    logic        e_rst;
    logic [1:0]  e_req [2];
    logic        m_busy [2];
    int          m_owner [2];
    int          m_last [2];
    int          m_k [2];
    int          m_lat [2];
    txn_t        m_cur [2];
    logic [63:0] m_rd [2][2];

    always #5 clk = ~clk;

    // Controller read data: a fixed pattern for 0x100, else derived from addr
    function automatic logic [63:0] sram_f(input logic [31:0] a);
        if (a == 32'h100) return 64'h1122334455667788;
        return {a ^ 32'hA5A5_5A5A, ~a};
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        sram_arbiter #(
            .RR (d == 0)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .req0_r_en  (r_en[d][0]),
            .req0_w_en  (w_en[d][0]),
            .req0_addr  (addr[d][0]),
            .req0_wdata (wdata[d][0]),
            .req0_rdata (rdata[d][0]),
            .req0_ready (rdy[d][0]),
            .req1_r_en  (r_en[d][1]),
            .req1_w_en  (w_en[d][1]),
            .req1_addr  (addr[d][1]),
            .req1_wdata (wdata[d][1]),
            .req1_rdata (rdata[d][1]),
            .req1_ready (rdy[d][1]),
            .sram_r_en  (s_r[d]),
            .sram_w_en  (s_w[d]),
            .sram_addr  (s_addr[d]),
            .sram_wdata (s_wdata[d]),
            .sram_rdata (s_rdata[d]),
            .sram_ready (s_rdy[d]),
            .grant      (grant[d]),
            .busy       (busy[d])
        );
        assign s_rdata[d] = sram_f(s_addr[d]);
    end

    // Controller model: ready idles high, then pulses lat cycles after enable
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!(s_r[d] | s_w[d])) begin
                c_cnt[d] <= 0;
                s_rdy[d] <= 1'b1;
            end else begin
                c_cnt[d] <= c_cnt[d] + 1;
                s_rdy[d] <= (c_cnt[d] + 1 == lat[d]);
            end
        end
    end

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL d%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
        end
    endtask

    // Winner rule: lone requester wins; RR picks the port not granted last
    function automatic int pick(input int d, input logic [1:0] rq, input int last);
        if (rq == 2'b01) return 0;
        if (rq == 2'b10) return 1;
        if (d == 0) return 1 - last;
        return 1;
    endfunction

    // Record the stimulus the DUTs saw at each rising edge
    always @(posedge clk) begin
        e_rst = rst;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                e_req[d][p] = r_en[d][p] | w_en[d][p];
            end
        end
        e_valid = 1'b1;
    end

    // Monitor: advance the model by one edge, then compare every output
    always @(negedge clk) begin
        if (e_valid) begin
            for (int d = 0; d < 2; d++) begin
                logic       done;
                logic [1:0] g_exp;
                int         w;
                if (!e_rst) begin
                    if (m_busy[d]) void'(exp_q[d*2+m_owner[d]].pop_front());
                    m_busy[d]   = 1'b0;
                    m_last[d]   = 1;
                    m_rd[d][0]  = 64'h0;
                    m_rd[d][1]  = 64'h0;
                end else if (!m_busy[d]) begin
                    if (e_req[d] != 2'b00) begin
                        w = pick(d, e_req[d], m_last[d]);
                        if (exp_q[d*2+w].size() == 0) begin
                            chk(d, "grant_without_txn", 64'(w), 64'hFFFF);
                        end else begin
                            m_busy[d]  = 1'b1;
                            m_owner[d] = w;
                            m_k[d]     = 0;
                            m_lat[d]   = lat[d];
                            m_cur[d]   = exp_q[d*2+w][0];
                        end
                    end
                end else if (m_k[d] == m_lat[d]) begin
                    m_busy[d] = 1'b0;
                    m_last[d] = m_owner[d];
                    m_rd[d][m_owner[d]] = sram_f(m_cur[d].addr);
                    void'(exp_q[d*2+m_owner[d]].pop_front());
                end else begin
                    m_k[d]++;
                end

                done  = m_busy[d] && (m_k[d] == m_lat[d]);
                g_exp = !m_busy[d] ? 2'b00 : ((m_owner[d] == 1) ? 2'b10 : 2'b01);
                chk(d, "sram_w_en", 64'(s_w[d]), 64'(m_busy[d] & m_cur[d].w));
                chk(d, "sram_r_en", 64'(s_r[d]), 64'(m_busy[d] & m_cur[d].r & ~m_cur[d].w));
                chk(d, "grant", 64'(grant[d]), 64'(g_exp));
                chk(d, "busy", 64'(busy[d]), 64'(m_busy[d]));
                if (m_busy[d]) begin
                    chk(d, "sram_addr", 64'(s_addr[d]), 64'(m_cur[d].addr));
                    chk(d, "sram_wdata", 64'(s_wdata[d]), 64'(m_cur[d].wdata));
                end
                if (!e_rst) begin
                    chk(d, "sram_addr_rst", 64'(s_addr[d]), 64'h0);
                    chk(d, "sram_wdata_rst", 64'(s_wdata[d]), 64'h0);
                end
                for (int p = 0; p < 2; p++) begin
                    logic own_done;
                    own_done = done && (m_owner[d] == p);
                    chk(d, $sformatf("ready%0d", p), 64'(rdy[d][p]),
                        64'(rst & (~(r_en[d][p] | w_en[d][p]) | own_done)));
                    chk(d, $sformatf("rdata%0d", p), rdata[d][p],
                        own_done ? sram_f(m_cur[d].addr) : m_rd[d][p]);
                end
            end
        end
    end

    // Push the expectation and present the request
    task automatic drive(input int d, input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.r = r; t.w = w; t.addr = a; t.wdata = wd;
        exp_q[d*2+p].push_back(t);
        r_en[d][p]  = r;
        w_en[d][p]  = w;
        addr[d][p]  = a;
        wdata[d][p] = wd;
    endtask

    // Full pipeline-style access: hold the request until ready, then release
    task automatic issue(input int d, input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
        bit got = 1'b0;
        drive(d, p, r, w, a, wd);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (rdy[d][p] === 1'b1) got = 1'b1;
        end
        if (!got) chk(d, $sformatf("ready%0d_timeout", p), 64'h0, 64'h1);
        @(posedge clk);
        #1;
        r_en[d][p] = 1'b0;
        w_en[d][p] = 1'b0;
    endtask

    task automatic rnd_issue(input int d, input int p);
        logic r, w;
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        issue(d, p, r, w, $urandom, $urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            lat[d] = 4;
            m_busy[d] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                r_en[d][p] = 1'b0; w_en[d][p] = 1'b0;
                addr[d][p] = 32'h0; wdata[d][p] = 32'h0;
                m_rd[d][p] = 64'h0;
            end
        end

        // Reset with both ports requesting; port 0 must win after release
        fork
            issue(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
            issue(0, 1, 1'b1, 1'b0, 32'h2000, 32'h0);
            begin
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        idle_cycles(3);

        // Single read with the fixed data pattern, then hold
        issue(0, 0, 1'b1, 1'b0, 32'h100, 32'h0);
        idle_cycles(4);

        // Read+write collision resolves to a write
        issue(0, 1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        idle_cycles(2);

        // Continuous contention on both instances
        lat[0] = $urandom_range(1, 5);
        lat[1] = $urandom_range(1, 5);
        fork
            for (int i = 0; i < 6; i++) rnd_issue(0, 0);
            for (int i = 0; i < 6; i++) rnd_issue(0, 1);
            for (int i = 0; i < 6; i++) rnd_issue(1, 1);
            for (int i = 0; i < 3; i++) rnd_issue(1, 0);
        join
        idle_cycles(3);

        // Port 1 drops its request in the second BUSY cycle
        lat[0] = 3;
        drive(0, 1, 1'b0, 1'b1, 32'h80, 32'hCAFE_F00D);
        idle_cycles(2);
        r_en[0][1] = 1'b0;
        w_en[0][1] = 1'b0;
        idle_cycles(8);

        // Reset in the middle of an access abandons it
        lat[0] = 4;
        drive(0, 0, 1'b1, 1'b0, 32'h300, 32'h0);
        idle_cycles(2);
        rst = 1'b0;
        r_en[0][0] = 1'b0;
        idle_cycles(1);
        rst = 1'b1;
        idle_cycles(4);

        // Randomised traffic with gaps
        lat[0] = $urandom_range(1, 5);
        lat[1] = $urandom_range(1, 5);
        fork
            for (int i = 0; i < 8; i++) begin idle_cycles($urandom_range(0, 3)); rnd_issue(0, 0); end
            for (int i = 0; i < 8; i++) begin idle_cycles($urandom_range(0, 3)); rnd_issue(0, 1); end
            for (int i = 0; i < 8; i++) begin idle_cycles($urandom_range(0, 3)); rnd_issue(1, 0); end
            for (int i = 0; i < 8; i++) begin idle_cycles($urandom_range(0, 3)); rnd_issue(1, 1); end
        join
        idle_cycles(6);

        for (int q = 0; q < 4; q++) begin
            chk(q / 2, $sformatf("queue%0d_left", q % 2), 64'(exp_q[q].size()), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SramController between two requesters: port 0 is the instruction-fetch path and port 1 is the data-cache miss/write path. It serialises accesses, holds the winning request stable on the controller until the controller reports completion, and steers completion and read data back to the owner. Each port sees the same enable/ready handshake the MEM stage uses. It sits between the pipeline-side caches and SramController.

## Interface
- `RR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where port 1 wins.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Synchronous, active-low reset; 0 = reset.
- `req0_r_en`, `req0_w_en`  in  1 each  Port 0 read and write request.
- `req0_addr`  in  32  Port 0 byte address.
- `req0_wdata`  in  32  Port 0 store value.
- `req0_rdata`  out  64  Port 0 read data.
- `req0_ready`  out  1  Port 0 ready.
- `req1_*`: the same six signals for port 1.
- `sram_r_en`, `sram_w_en`  out  1 each  Registered enables to SramController.
- `sram_addr`  out  32  Registered address to SramController.
- `sram_wdata`  out  32  Registered store value to SramController.
- `sram_rdata`  in  64  Read data from SramController.
- `sram_ready`  in  1  SramController ready/completion.
- `grant`  out  2  One-hot current owner; 0 when idle.
- `busy`  out  1  High while in BUSY.

## Operation
- A port is requesting when `r_en | w_en`. If both are high, the access is a write.
- **`reqN_ready`** is combinational:
  - 1 when port N is not requesting.
  - 1 in the completion cycle of port N's access.
  - 0 otherwise, including while the other port owns the controller.
- States: IDLE and BUSY.
- **IDLE:**
  - If no port is requesting, stay in IDLE.
  - Otherwise pick a winner and register the winner's enables, addr and wdata onto `sram_*`.
  - Set `grant` to the winner, set the `first` flag, and go to BUSY.
- **Arbitration:**
  - With RR=1, if both ports are requesting, the port not granted last wins; a single requester always wins.
  - `last` resets to 1, so port 0 wins the first contention.
  - With RR=0, port 1 wins any contention.
- **BUSY:**
  - `sram_*` are held constant.
  - `sram_ready` is ignored in the first BUSY cycle (`first`=1). This masks the controller's idle-ready level.
  - From the second BUSY cycle on, `sram_ready`=1 is completion:
    - owner's `ready`=1 that cycle;
    - owner's `rdata` = `sram_rdata` combinationally and is also captured into that port's `rdata` register;
    - `sram_r_en`/`sram_w_en` are cleared on the edge, `last` is updated to the owner, and the state returns to IDLE.
- **Requester drops its request mid-access:** the access still runs to completion because SRAM writes cannot be aborted. The completion pulse is still generated.
- **`reqN_rdata`:** outside its completion cycle it holds that port's last captured value, so stalled pipelines re-read stable data.

## Timing
- Reset (rst=0 at an edge):
  - state IDLE, `grant`=0, `busy`=0, `first`=0, `last`=1;
  - `sram_r_en`=`sram_w_en`=0, `sram_addr`=`sram_wdata`=0;
  - both rdata registers = 0.
- While rst=0, both `ready` outputs are forced to 0.
- Reset asserted mid-BUSY abandons the access. Enables drop at that edge, so no completion pulse is generated.
- A request seen in IDLE at edge T drives enables from T+1. The minimum port-visible latency is 2 cycles plus the controller latency.
- After every completion, the enables are low for at least one full cycle (the IDLE cycle) before the next grant. This gives SramController a clean release.
- A new request arriving in the completion cycle is arbitrated in the following IDLE cycle. There is no back-to-back grant.

## Structure
- Shared package `arb_pkg`: the state enum {IDLE, BUSY} and the port index constants PORT_IF=0 and PORT_MEM=1.
- Sub-module `rr_pick2`: combinational winner selection from `(req[1:0], last, RR)` to a one-hot winner. It is instantiated once and tested standalone.
- Address/data steering, the output registers and the FSM all live in `sram_arbiter`.

## Test plan
- **Reset:** rst=0 for 2 cycles with both ports requesting. Required: both ready=0, `sram_r_en`=`sram_w_en`=0, `grant`=0. After release, port 0 is granted first.
- **Single read:** port 0 reads addr 0x100; the controller model gives `sram_ready` 4 cycles after the enable with rdata 0x1122334455667788. Required: `req0_ready` pulses once and `req0_rdata` = 0x1122334455667788 and holds afterwards.
- **Contention, RR=1:** both ports request continuously. Required: grants alternate 0,1,0,1, and each access is followed by ≥1 cycle of enables low.
- **Contention, RR=0:** both ports request. Required: port 1 always wins, and port 0 is served only once port 1 goes idle.
- **Write + read collision:** port 1 drives `r_en`=`w_en`=1 with addr 0x40 and wdata 0xDEADBEEF. Required: `sram_w_en`=1, `sram_r_en`=0, `sram_wdata`=0xDEADBEEF.
- **Early drop and mid-access reset:**
  - Port 1 drops its request in the second BUSY cycle. Required: enables stay held until `sram_ready`, and the completion pulse still occurs.
  - rst=0 in a separate BUSY access. Required: enables low next cycle and no ready pulse.
